// File: rtl/ipml_hsst_fifo_clr_v2_0.sv
// rtl/ipml_hsst_fifo_clr_v2_0.sv - HSST RX bonding-group FIFO-clear controller
// Optional per-group clear statistics: define IPML_HSST_FIFO_CLR_STATS_EN.
module ipml_hsst_fifo_clr_v2_0 #(
  parameter int NUM_LANES        = 4,
  parameter int GROUP_SIZE       = 4,
  parameter int SETTLE_CYCLES    = 16,
  parameter int CLR_PULSE_CYCLES = 4,
  parameter logic [NUM_LANES-1:0]              RX_EN_MASK  = {NUM_LANES{1'b1}},
  parameter logic [(NUM_LANES/GROUP_SIZE)-1:0] BYPASS_MASK = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_LANES-1:0]                  lane_rst_n,
  input  logic [NUM_LANES-1:0]                  i_fifo_clr,
  input  logic [NUM_LANES-1:0]                  cdr_align,
  input  logic [NUM_LANES-1:0]                  rxlane_done,
  output logic [NUM_LANES-1:0]                  fifo_clr_en,
  output logic [(NUM_LANES/GROUP_SIZE)-1:0]     grp_busy,
  output logic [8*(NUM_LANES/GROUP_SIZE)-1:0]   clr_evt_cnt
);

  localparam int NUM_GROUPS = NUM_LANES / GROUP_SIZE;
  localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST  = 8'(CLR_PULSE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CLEAR} state_t;

  logic [NUM_LANES-1:0]  cdr_vld;
  logic [NUM_LANES-1:0]  ff1;
  logic [NUM_LANES-1:0]  pos;
  logic [NUM_LANES-1:0]  lock;
  logic [NUM_GROUPS-1:0] grp_lock_clr;
  logic                  unused_ok;

  // i_fifo_clr only matters for bypassed groups
  assign unused_ok = ^i_fifo_clr;

  assign cdr_vld = cdr_align & RX_EN_MASK;
  assign pos     = cdr_vld & ~ff1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1  <= '0;
      lock <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!lane_rst_n[i]) begin
          ff1[i]  <= 1'b0;
          lock[i] <= 1'b0;
        end else begin
          ff1[i] <= cdr_vld[i];
          if (grp_lock_clr[i / GROUP_SIZE])
            lock[i] <= 1'b0;
          else if (pos[i])
            lock[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    localparam int BASE = g * GROUP_SIZE;

    if (GROUP_SIZE == 1) begin : g_nobond
      assign fifo_clr_en[BASE +: GROUP_SIZE] = '0;
      assign grp_busy[g]                     = 1'b0;
      assign clr_evt_cnt[g*8 +: 8]           = 8'd0;
      assign grp_lock_clr[g]                 = 1'b0;

    end else if (BYPASS_MASK[g]) begin : g_bypass
      logic [GROUP_SIZE-1:0] clr_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_q <= '0;
        else        clr_q <= i_fifo_clr[BASE +: GROUP_SIZE];
      end

      assign fifo_clr_en[BASE +: GROUP_SIZE] = clr_q;
      assign grp_busy[g]                     = 1'b0;
      assign clr_evt_cnt[g*8 +: 8]           = 8'd0;
      // locks are meaningless here; keep them parked at 0
      assign grp_lock_clr[g]                 = 1'b1;

    end else begin : g_fsm
      state_t                state, state_nxt;
      logic [7:0]            cnt, cnt_nxt;
      logic                  busy_q;
      logic                  clr_d;
      logic [GROUP_SIZE-1:0] clr_q;
      logic                  any_lock, all_done, lrst_any;

      assign any_lock = |lock[BASE +: GROUP_SIZE];
      assign all_done = &rxlane_done[BASE +: GROUP_SIZE];
      assign lrst_any = ~&lane_rst_n[BASE +: GROUP_SIZE];

      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
          IDLE: begin
            cnt_nxt = 8'd0;
            if (any_lock && all_done) begin
              if (SETTLE_CYCLES == 0) state_nxt = CLEAR;
              else                    state_nxt = SETTLE;
            end
          end
          SETTLE: begin
            if (!all_done || lrst_any) begin
              state_nxt = IDLE;
              cnt_nxt   = 8'd0;
            end else if (cnt == SETTLE_LAST) begin
              state_nxt = CLEAR;
              cnt_nxt   = 8'd0;
            end else begin
              cnt_nxt = cnt + 8'd1;
            end
          end
          CLEAR: begin
            if (cnt == PULSE_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = 8'd0;
            end else begin
              cnt_nxt = cnt + 8'd1;
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        endcase
      end

      // entry cycle of CLEAR drives nothing; the pulse follows for PULSE_LAST cycles
      assign clr_d = (state == CLEAR) && (cnt != PULSE_LAST);

      // the final CLEAR cycle releases the locks so an edge there is kept
      assign grp_lock_clr[g] = (state_nxt == CLEAR) ||
                               ((state == SETTLE) && (state_nxt == IDLE));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state  <= IDLE;
          cnt    <= 8'd0;
          busy_q <= 1'b0;
          clr_q  <= '0;
        end else begin
          state  <= state_nxt;
          cnt    <= cnt_nxt;
          busy_q <= (state_nxt != IDLE);
          clr_q  <= {GROUP_SIZE{clr_d}};
        end
      end

      assign fifo_clr_en[BASE +: GROUP_SIZE] = clr_q;
      assign grp_busy[g]                     = busy_q;

`ifdef IPML_HSST_FIFO_CLR_STATS_EN
      logic [7:0] evt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          evt_q <= 8'd0;
        else if ((state != CLEAR) && (state_nxt == CLEAR) && (evt_q != 8'hFF))
          evt_q <= evt_q + 8'd1;
      end

      assign clr_evt_cnt[g*8 +: 8] = evt_q;
`else
      assign clr_evt_cnt[g*8 +: 8] = 8'd0;
`endif
    end
  end

endmodule

// File: doc/ipml_hsst_fifo_clr_v2_0.md
Name: ipml_hsst_fifo_clr_v2_0

Overview:
Generalised HSST RX FIFO-clear controller for N lanes organised into equal bonding groups. It detects per-lane CDR-align rising edges and waits for every lane in the group to report rxlane_done. After a programmable settle time it issues a multi-cycle FIFO-clear pulse to all lanes of the group. It sits beside the HSST reset sequencer and drives the PCS channel-bonding FIFO clear inputs. Bypassed groups pass the user clear through a register.

Parameters:
NUM_LANES, 4, lane count; 1..8; must be a multiple of GROUP_SIZE
GROUP_SIZE, 4, lanes per bonding group; 1, 2 or 4; 1 = no bonding, all clears tied 0
NUM_GROUPS, NUM_LANES/GROUP_SIZE, derived; not overridable
SETTLE_CYCLES, 16, clk cycles that lock and all-done must hold before a clear; 0..255
CLR_PULSE_CYCLES, 4, width of the fifo_clr_en pulse in clk cycles; 1..255
RX_EN_MASK, {NUM_LANES{1'b1}}, per-lane RX enable; a 0 bit forces that lane's cdr_align to 0
BYPASS_MASK, {NUM_GROUPS{1'b0}}, per-group bonding bypass; a 1 bit selects the user-clear path

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset; clears all state
lane_rst_n  in  NUM_LANES  synchronous per-lane soft reset, active-low; clears that lane's edge/lock flops
i_fifo_clr  in  NUM_LANES  user clear request, used only by bypassed groups
cdr_align  in  NUM_LANES  CDR aligned per lane, already synchronised to clk
rxlane_done  in  NUM_LANES  RX lane reset sequence complete
fifo_clr_en  out  NUM_LANES  FIFO clear to PCS, registered
grp_busy  out  NUM_GROUPS  group FSM not in IDLE
clr_evt_cnt  out  8*NUM_GROUPS  per-group saturating count of issued clears (optional feature)

Behaviour:
- Reset: all outputs 0, FSMs in IDLE, edge/lock flops 0, counters 0.
- Per lane: cdr_vld = cdr_align & RX_EN_MASK. ff1 <= cdr_vld. pos = cdr_vld & ~ff1.
- Per-lane lock: set on pos. Cleared by lane_rst_n=0, by entering CLEAR, or by the abort transition. Clear has priority over set.
- Group g covers lanes [g*GROUP_SIZE +: GROUP_SIZE]. any_lock = OR of the group's locks. all_done = AND of the group's rxlane_done.
- FSM per non-bypassed group (GROUP_SIZE>1):
  IDLE: if any_lock & all_done -> SETTLE (cnt=0). If SETTLE_CYCLES==0 -> CLEAR directly.
  SETTLE: cnt++ each cycle. If !all_done -> IDLE, clearing the group's locks (abort). If cnt==SETTLE_CYCLES-1 -> CLEAR (cnt=0).
  CLEAR: fifo_clr_en for the group's lanes =1 starting the cycle after entry, for exactly CLR_PULSE_CYCLES cycles. rxlane_done changes are ignored. Then -> IDLE.
  A new pos during CLEAR is lost: locks are held cleared while in CLEAR. A pos in the IDLE-exit cycle is captured.
- Latency, nominal: pos at cycle 0 with all_done=1 -> lock set cycle 1 -> SETTLE cycle 2 -> fifo_clr_en rises at cycle 3+SETTLE_CYCLES.
- Bypassed group: no FSM activity. fifo_clr_en[lanes] <= i_fifo_clr[lanes] (1-cycle latency). grp_busy=0.
- GROUP_SIZE==1: fifo_clr_en=0 and grp_busy=0 constantly. Lock logic may be optimised away.
- grp_busy = (state!=IDLE), registered.
- rst_n asserted mid-pulse: fifo_clr_en drops asynchronously.
- lane_rst_n low on any lane of a group in SETTLE: aborts to IDLE. lane_rst_n low in CLEAR: ignored.
- Counter widths: cnt is 8-bit. Comparisons are done at 8 bits.

Optional Feature:
Macro IPML_HSST_FIFO_CLR_STATS_EN.
- Defined: clr_evt_cnt[g*8 +: 8] increments by 1 on each CLEAR entry and saturates at 255. It is reset only by rst_n.
- Undefined: clr_evt_cnt is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Defaults (4 lanes, 1 group), all rxlane_done=1, cdr_align[2] rises at cycle 0 -> fifo_clr_en=4'b1111 during cycles 19..22, then 0; grp_busy=1 during cycles 2..22.
- GROUP_SIZE=2, NUM_LANES=4, cdr_align[0] rises while rxlane_done=4'b0011 -> fifo_clr_en=4'b0011 for 4 cycles. Lanes 3:2 stay 0 and grp_busy[1] stays 0.
- Defaults, lock set, rxlane_done[1] drops at SETTLE cycle 5 -> return to IDLE, locks cleared, no pulse. Re-raising rxlane_done without a new cdr edge produces no clear.
- BYPASS_MASK=2'b10, GROUP_SIZE=2, i_fifo_clr=4'b1000 held for 3 cycles -> fifo_clr_en=4'b1000 for 3 cycles, delayed 1 cycle.
- rst_n pulsed low during the 2nd pulse cycle -> fifo_clr_en=0 immediately, grp_busy=0, and no clear after release until a new cdr edge.
- STATS_EN defined, 300 clear sequences on group 0 -> clr_evt_cnt[7:0]=255.
